// File: rtl/ls_ctrl_pkg.sv
// Shared types and default encodings for the ld/ldi/st control sequencer.
package ls_ctrl_pkg;

  localparam int         OPC_W_DEF       = 5;
  localparam logic [4:0] OPC_LD_DEF      = 5'b00000;
  localparam logic [4:0] OPC_LDI_DEF     = 5'b00001;
  localparam logic [4:0] OPC_ST_DEF      = 5'b00010;
  localparam logic [4:0] ALU_ADD_DEF     = 5'b00000;
  localparam int         MEM_TIMEOUT_DEF = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/ls_ctrl_seq_mem_wait_timer.sv
// Counts stalled memory-wait cycles and flags the cycle that reaches the limit.
// Only instantiated when LS_CTRL_TIMEOUT_EN is defined.
module mem_wait_timer #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // The stalled cycle that would bring the count up to LIMIT is the one that expires.
  assign expire = inc && (count == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/ls_ctrl_seq.sv
// Moore sequencer driving Datapath strobes for ld/ldi/st: fetch, execute, memory handshakes.
// Define LS_CTRL_TIMEOUT_EN to bound each memory wait at MEM_TIMEOUT stalled cycles.
module ls_ctrl_seq
  import ls_ctrl_pkg::*;
#(
  parameter int               OPC_W   = OPC_W_DEF,
  parameter logic [OPC_W-1:0] OPC_LD  = OPC_W'(OPC_LD_DEF),
  parameter logic [OPC_W-1:0] OPC_LDI = OPC_W'(OPC_LDI_DEF),
  parameter logic [OPC_W-1:0] OPC_ST  = OPC_W'(OPC_ST_DEF),
  parameter logic [4:0]       ALU_ADD = ALU_ADD_DEF
`ifdef LS_CTRL_TIMEOUT_EN
  , parameter int             MEM_TIMEOUT = MEM_TIMEOUT_DEF
`endif
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Start,
  input  logic [OPC_W-1:0] Opcode,
  input  logic             Mem_Ready,
  output logic             IncPC,
  output logic             Read,
  output logic             Write,
  output logic             PC_Out,
  output logic             MDR_Out,
  output logic             ZLO_Out,
  output logic             C_Out,
  output logic             PC_In,
  output logic             MDR_In,
  output logic             MAR_In,
  output logic             IR_In,
  output logic             Y_In,
  output logic             ZLO_In,
  output logic             G_RA,
  output logic             G_RB,
  output logic             BA_Out,
  output logic             R_In,
  output logic             R_Out,
  output logic [4:0]       CONTROL,
  output logic             Busy,
  output logic             Done,
  output logic             Error
);

  state_t           state_q, state_d;
  logic [OPC_W-1:0] opc_q;
  logic             op_ld, op_ldi, op_st, opc_legal;
  logic             timeout_hit;

  assign op_ld     = (opc_q == OPC_LD);
  assign op_ldi    = (opc_q == OPC_LDI);
  assign op_st     = (opc_q == OPC_ST);
  assign opc_legal = (Opcode == OPC_LD) || (Opcode == OPC_LDI) || (Opcode == OPC_ST);

`ifdef LS_CTRL_TIMEOUT_EN
  logic in_wait;

  assign in_wait = (state_q == S_T1) ||
                   ((state_q == S_T6) && op_ld) ||
                   ((state_q == S_T7) && op_st);

  mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timer (
    .clk    (Clock),
    .rst_n  (Clear),
    .clear  (!in_wait || Mem_Ready),
    .inc    (in_wait && !Mem_Ready),
    .expire (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_T3) begin
        opc_q <= Opcode;
      end
    end
  end

  // Next state plus strobe decode; strobes depend only on the state register and latched opcode.
  always_comb begin
    state_d = state_q;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    PC_Out  = 1'b0;
    MDR_Out = 1'b0;
    ZLO_Out = 1'b0;
    C_Out   = 1'b0;
    PC_In   = 1'b0;
    MDR_In  = 1'b0;
    MAR_In  = 1'b0;
    IR_In   = 1'b0;
    Y_In    = 1'b0;
    ZLO_In  = 1'b0;
    G_RA    = 1'b0;
    G_RB    = 1'b0;
    BA_Out  = 1'b0;
    R_In    = 1'b0;
    R_Out   = 1'b0;
    CONTROL = 5'b0;
    Busy    = (state_q != S_IDLE);
    Done    = 1'b0;
    Error   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_T0;
      end
      S_T0: begin
        PC_Out  = 1'b1;
        MAR_In  = 1'b1;
        IncPC   = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Read   = 1'b1;
        MDR_In = 1'b1;
        if (Mem_Ready)        state_d = S_T2;
        else if (timeout_hit) state_d = S_ERR;
      end
      S_T2: begin
        MDR_Out = 1'b1;
        IR_In   = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        G_RB    = 1'b1;
        BA_Out  = 1'b1;
        Y_In    = 1'b1;
        state_d = opc_legal ? S_T4 : S_ERR;
      end
      S_T4: begin
        C_Out   = 1'b1;
        ZLO_In  = 1'b1;
        CONTROL = ALU_ADD;
        state_d = S_T5;
      end
      S_T5: begin
        ZLO_Out = 1'b1;
        if (op_ldi) begin
          G_RA    = 1'b1;
          R_In    = 1'b1;
          state_d = S_DONE;
        end else begin
          MAR_In  = 1'b1;
          state_d = S_T6;
        end
      end
      S_T6: begin
        MDR_In = 1'b1;
        if (op_st) begin
          G_RA    = 1'b1;
          R_Out   = 1'b1;
          state_d = S_T7;
        end else begin
          Read = 1'b1;
          if (Mem_Ready)        state_d = S_T7;
          else if (timeout_hit) state_d = S_ERR;
        end
      end
      S_T7: begin
        MDR_Out = 1'b1;
        if (op_st) begin
          Write = 1'b1;
          if (Mem_Ready)        state_d = S_DONE;
          else if (timeout_hit) state_d = S_ERR;
        end else begin
          G_RA    = 1'b1;
          R_In    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        Error   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ls_ctrl_seq.sv
// Bench for ls_ctrl_seq: table of instructions with known latencies, randomized runs checked
// cycle-by-cycle against a step-list model, plus async-clear and (LS_CTRL_TIMEOUT_EN) timeout cases.
module tb_ls_ctrl_seq;

  typedef logic [25:0] word_t;

  localparam int B_INC = 0, B_RD = 1, B_WR = 2, B_PCO = 3, B_MDRO = 4, B_ZLOO = 5, B_CO = 6;
  localparam int B_PCI = 7, B_MDRI = 8, B_MARI = 9, B_IRI = 10, B_YI = 11, B_ZLOI = 12;
  localparam int B_GRA = 13, B_GRB = 14, B_BAO = 15, B_RI = 16, B_RO = 17;
  localparam int B_BUSY = 18, B_DONE = 19, B_ERR = 20;

  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;

  logic       Clock = 1'b0;
  logic       Clear, Start, Mem_Ready;
  logic [4:0] Opcode;
  logic       IncPC, Read, Write, PC_Out, MDR_Out, ZLO_Out, C_Out, PC_In, MDR_In, MAR_In;
  logic       IR_In, Y_In, ZLO_In, G_RA, G_RB, BA_Out, R_In, R_Out, Busy, Done, Error;
  logic [4:0] CONTROL;

  int tests = 0;
  int failures = 0;

  typedef struct {
    word_t word;
    logic  ready;
    bit    is_t3;
  } step_t;

  step_t trace[$];

  typedef struct {
    logic [4:0] opc;
    int         s1;
    int         s2;
    int         lat;
  } vec_t;

  vec_t vecs[9];

  ls_ctrl_seq dut (
    .Clock(Clock), .Clear(Clear), .Start(Start), .Opcode(Opcode), .Mem_Ready(Mem_Ready),
    .IncPC(IncPC), .Read(Read), .Write(Write), .PC_Out(PC_Out), .MDR_Out(MDR_Out),
    .ZLO_Out(ZLO_Out), .C_Out(C_Out), .PC_In(PC_In), .MDR_In(MDR_In), .MAR_In(MAR_In),
    .IR_In(IR_In), .Y_In(Y_In), .ZLO_In(ZLO_In), .G_RA(G_RA), .G_RB(G_RB), .BA_Out(BA_Out),
    .R_In(R_In), .R_Out(R_Out), .CONTROL(CONTROL), .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clock = ~Clock;

  function automatic word_t sb(input int b);
    return word_t'(1) << b;
  endfunction

  function automatic word_t pack_outputs();
    return {CONTROL, Error, Done, Busy, R_Out, R_In, BA_Out, G_RB, G_RA, ZLO_In, Y_In, IR_In,
            MAR_In, MDR_In, PC_In, C_Out, ZLO_Out, MDR_Out, PC_Out, Write, Read, IncPC};
  endfunction

  task automatic check_output(input string name, input word_t got, input word_t exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic void push(input word_t w, input bit t3);
    step_t s;
    s.word  = w | sb(B_BUSY);
    s.ready = 1'($urandom);
    s.is_t3 = t3;
    trace.push_back(s);
  endfunction

  function automatic void push_wait(input word_t w, input int stalls);
    step_t s;
    s.word  = w | sb(B_BUSY);
    s.is_t3 = 1'b0;
    for (int k = 0; k <= stalls; k++) begin
      s.ready = (k == stalls);
      trace.push_back(s);
    end
  endfunction

  // Expected per-cycle output words from T0 through DONE/ERR, built from the step table.
  function automatic void build_trace(input logic [4:0] opc, input int s1, input int s2);
    trace.delete();
    push(sb(B_PCO) | sb(B_MARI) | sb(B_INC), 1'b0);
    push_wait(sb(B_RD) | sb(B_MDRI), s1);
    push(sb(B_MDRO) | sb(B_IRI), 1'b0);
    push(sb(B_GRB) | sb(B_BAO) | sb(B_YI), 1'b1);
    if (opc != OP_LD && opc != OP_LDI && opc != OP_ST) begin
      push(sb(B_ERR), 1'b0);
      return;
    end
    push(sb(B_CO) | sb(B_ZLOI), 1'b0);
    if (opc == OP_LDI) begin
      push(sb(B_ZLOO) | sb(B_GRA) | sb(B_RI), 1'b0);
    end else if (opc == OP_LD) begin
      push(sb(B_ZLOO) | sb(B_MARI), 1'b0);
      push_wait(sb(B_RD) | sb(B_MDRI), s2);
      push(sb(B_MDRO) | sb(B_GRA) | sb(B_RI), 1'b0);
    end else begin
      push(sb(B_ZLOO) | sb(B_MARI), 1'b0);
      push(sb(B_GRA) | sb(B_RO) | sb(B_MDRI), 1'b0);
      push_wait(sb(B_WR) | sb(B_MDRO), s2);
    end
    push(sb(B_DONE), 1'b0);
  endfunction

  // Runs one instruction; Opcode is garbage except in T3 and Start toggles randomly while busy.
  task automatic apply_stimulus(input logic [4:0] opc, input int s1, input int s2, output int latency);
    word_t got;
    build_trace(opc, s1, s2);
    latency = -1;
    @(negedge Clock);
    Start     = 1'b1;
    Mem_Ready = 1'($urandom);
    Opcode    = 5'($urandom);
    @(posedge Clock);
    #1;
    foreach (trace[i]) begin
      Start     = 1'($urandom);
      Mem_Ready = trace[i].ready;
      Opcode    = trace[i].is_t3 ? opc : 5'($urandom);
      got = pack_outputs();
      if ((got[B_DONE] || got[B_ERR]) && latency < 0) latency = i + 1;
      check_output($sformatf("trace op=%b s1=%0d s2=%0d step %0d", opc, s1, s2, i), got, trace[i].word);
      @(posedge Clock);
      #1;
    end
    Start = 1'b0;
    check_output($sformatf("idle after op=%b", opc), pack_outputs(), '0);
  endtask

  initial begin
    int lat;
    logic [4:0] opc;
    Clear = 1'b1; Start = 1'b0; Mem_Ready = 1'b0; Opcode = '0;
    #1 Clear = 1'b0;
    #3 check_output("reset outputs", pack_outputs(), '0);
    @(negedge Clock);
    Clear = 1'b1;
    @(posedge Clock);
    #1 check_output("idle without start", pack_outputs(), '0);

    vecs[0] = '{OP_LDI, 0, 0, 7};
    vecs[1] = '{OP_ST, 0, 3, 12};
    vecs[2] = '{OP_LD, 2, 0, 11};
    vecs[3] = '{5'b11111, 0, 0, 5};
    vecs[4] = '{OP_LD, 0, 0, 9};
    vecs[5] = '{OP_ST, 0, 0, 9};
    vecs[6] = '{OP_LD, 1, 2, 12};
    vecs[7] = '{OP_LDI, 4, 0, 11};
    vecs[8] = '{5'b00011, 2, 0, 7};
    for (int v = 0; v < 9; v++) begin
      apply_stimulus(vecs[v].opc, vecs[v].s1, vecs[v].s2, lat);
      check_int($sformatf("latency vec %0d", v), lat, vecs[v].lat);
    end

    // Async clear while a store sits in T6, then a fresh instruction.
    @(negedge Clock);
    Start = 1'b1; Opcode = OP_ST; Mem_Ready = 1'b1;
    @(posedge Clock);
    #1 Start = 1'b0;
    repeat (6) @(posedge Clock);
    #1 check_output("st in T6", pack_outputs(), sb(B_GRA) | sb(B_RO) | sb(B_MDRI) | sb(B_BUSY));
    #2 Clear = 1'b0;
    #1 check_output("async clear", pack_outputs(), '0);
    @(posedge Clock);
    #1 check_output("held in clear", pack_outputs(), '0);
    @(negedge Clock);
    Clear = 1'b1;
    @(posedge Clock);
    #1 check_output("idle after clear", pack_outputs(), '0);
    apply_stimulus(OP_LDI, 0, 0, lat);
    check_int("latency after clear", lat, 7);

`ifdef LS_CTRL_TIMEOUT_EN
    @(negedge Clock);
    Start = 1'b1; Opcode = OP_LD; Mem_Ready = 1'b0;
    @(posedge Clock);
    #1 Start = 1'b0;
    @(posedge Clock);
    #1;
    for (int k = 0; k < 8; k++) begin
      check_output($sformatf("timeout T1 stall %0d", k), pack_outputs(), sb(B_RD) | sb(B_MDRI) | sb(B_BUSY));
      @(posedge Clock);
      #1;
    end
    check_output("timeout error", pack_outputs(), sb(B_ERR) | sb(B_BUSY));
    @(posedge Clock);
    #1 check_output("idle after timeout", pack_outputs(), '0);
`endif

    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0:       opc = OP_LD;
        1:       opc = OP_LDI;
        2:       opc = OP_ST;
        default: opc = 5'($urandom_range(3, 31));
      endcase
      apply_stimulus(opc, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
